// File: rtl/data_sram_if.sv
// Data SRAM request/response bus: the master issues single-beat accesses,
// the slave returns registered read data, a completion pulse and a sticky error.
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic        data_sram_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, data_sram_rvalid, data_sram_err
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, data_sram_rvalid, data_sram_err
  );
endinterface

// File: rtl/data_sram_responder.sv
// Single-port word SRAM with byte-lane writes, pipelined reads of 1 or 2 cycles
// latency, and a sticky flag for accesses outside the populated address range.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic      clk,
  input  logic      resetn,
  data_sram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]              mem [DEPTH];
  logic [ADDR_W-1:0]        idx;
  logic                     in_range;
  logic                     rd_acc;
  logic                     wr_acc;
  logic [31:0]              rd_word;
  logic [LATENCY-1:0]       vld_pipe;
  logic [LATENCY-1:0][31:0] dat_pipe;
  logic                     err_q;
  logic                     unused_addr_lsb;

  assign idx             = bus.data_sram_addr[ADDR_W+1:2];
  assign in_range        = (bus.data_sram_addr[31:ADDR_W+2] == '0);
  assign rd_acc          = bus.data_sram_en && (bus.data_sram_wen == 4'h0);
  assign wr_acc          = bus.data_sram_en && (bus.data_sram_wen != 4'h0);
  assign rd_word         = in_range ? mem[idx] : 32'h0;
  assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

  // Array has no reset so contents survive resetn; accesses are still blocked in reset.
  always_ff @(posedge clk) begin
    if (resetn && wr_acc && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_wen[b]) mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
      end
    end
  end

  // Each data stage only loads on a valid beat, so the last stage holds the
  // most recent completed read between completions.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_pipe[0] <= rd_acc;
      if (rd_acc) dat_pipe[0] <= rd_word;
      for (int s = 1; s < LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
      if (bus.data_sram_en && !in_range) err_q <= 1'b1;
    end
  end

  assign bus.data_sram_rdata  = dat_pipe[LATENCY-1];
  assign bus.data_sram_rvalid = vld_pipe[LATENCY-1];
  assign bus.data_sram_err    = err_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Drives one stimulus stream into a LATENCY=1 and a LATENCY=2 responder and
// scoreboards both against a word-array model of the memory.
module tb_data_sram_responder;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;

  data_sram_if bus1 ();
  data_sram_if bus2 ();

  assign bus1.data_sram_en    = en;
  assign bus1.data_sram_wen   = wen;
  assign bus1.data_sram_addr  = addr;
  assign bus1.data_sram_wdata = wdata;
  assign bus2.data_sram_en    = en;
  assign bus2.data_sram_wen   = wen;
  assign bus2.data_sram_addr  = addr;
  assign bus2.data_sram_wdata = wdata;

  data_sram_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
  data_sram_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

  always #5 clk = ~clk;

  logic        rv [2];
  logic        er [2];
  logic [31:0] rd [2];
  assign rv[0] = bus1.data_sram_rvalid;
  assign rv[1] = bus2.data_sram_rvalid;
  assign er[0] = bus1.data_sram_err;
  assign er[1] = bus2.data_sram_err;
  assign rd[0] = bus1.data_sram_rdata;
  assign rd[1] = bus2.data_sram_rdata;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        mon_on = 1'b0;
  logic [31:0] model [1024];
  logic        m_err = 1'b0;
  logic [31:0] last [2];
  exp_t        q [2][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected read for each completion and checks its cycle.
  always @(negedge clk) begin
    if (mon_on && resetn) begin
      for (int k = 0; k < 2; k++) begin
        if (rv[k]) begin
          if (q[k].size() == 0) begin
            total++; bad++;
            $display("FAIL lat%0d_spurious_rvalid got=1 want=0 (t=%0t)", k + 1, $time);
          end else begin
            exp_t e;
            e = q[k].pop_front();
            chk($sformatf("lat%0d_rdata", k + 1), rd[k], e.data);
            chk($sformatf("lat%0d_cycle", k + 1), cyc, e.cyc);
            last[k] = e.data;
          end
        end else begin
          chk($sformatf("lat%0d_hold", k + 1), rd[k], last[k]);
          if (q[k].size() != 0 && q[k][0].cyc <= cyc) begin
            exp_t e;
            e = q[k].pop_front();
            total++; bad++;
            $display("FAIL lat%0d_missing_rvalid got=0 want=1 cycle=%0d", k + 1, e.cyc);
          end
        end
        chk($sformatf("lat%0d_err", k + 1), er[k], m_err);
      end
    end
  end

  // One bus cycle: present inputs, predict the read, then apply writes after the edge.
  task automatic do_op(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic       inr;
    logic [9:0] ix;
    exp_t       x;
    inr = (a[31:12] == 20'h0);
    ix  = a[11:2];
    en = e; wen = w; addr = a; wdata = d;
    if (e && w == 4'h0) begin
      x.data = inr ? model[ix] : 32'h0;
      x.cyc  = cyc + 1;
      q[0].push_back(x);
      x.cyc  = cyc + 2;
      q[1].push_back(x);
    end
    @(posedge clk);
    if (e && !inr) m_err = 1'b1;
    if (e && w != 4'h0 && inr) begin
      for (int b = 0; b < 4; b++) if (w[b]) model[ix][8*b +: 8] = d[8*b +: 8];
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] idle_addr [100];
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    last[0] = 32'h0; last[1] = 32'h0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("lat%0d_reset_rdata", k + 1), rd[k], 32'h0);
      chk($sformatf("lat%0d_reset_rvalid", k + 1), {31'h0, rv[k]}, 32'h0);
      chk($sformatf("lat%0d_reset_err", k + 1), {31'h0, er[k]}, 32'h0);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;

    for (int i = 0; i < 1024; i++) do_op(1'b1, 4'hF, i * 4, $urandom);

    // Byte-lane merge
    do_op(1'b1, 4'hF,    32'h40, 32'h11223344);
    do_op(1'b1, 4'b0101, 32'h40, 32'hAABBCCDD);
    do_op(1'b1, 4'h0,    32'h40, 32'h0);
    chk("lane_model", model[16], 32'h11BB33DD);

    // Write immediately followed by read of the same word
    do_op(1'b1, 4'hF, 32'h8, 32'hDEADBEEF);
    do_op(1'b1, 4'h0, 32'h8, 32'h0);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) do_op(1'b1, 4'hF, i * 4, i + 1);
    for (int i = 0; i < 4; i++) do_op(1'b1, 4'h0, i * 4, 32'h0);

    // Idle cycles with garbage on the other inputs, then read those words back
    for (int i = 0; i < 100; i++) begin
      idle_addr[i] = $urandom;
      do_op(1'b0, 4'hF, idle_addr[i], $urandom);
    end
    for (int i = 0; i < 100; i++) do_op(1'b1, 4'h0, idle_addr[i] & 32'hFFF, 32'h0);

    // Out of range
    do_op(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
    do_op(1'b1, 4'h0, 32'h0,    32'h0);
    do_op(1'b1, 4'h0, 32'h1000, 32'h0);
    do_op(1'b1, 4'h0, 32'h40,   32'h0);

    // Reset while a read is in flight
    do_op(1'b1, 4'h0, 32'h40, 32'h0);
    en = 1'b0;
    #2;
    resetn = 1'b0;
    q[0].delete(); q[1].delete();
    m_err = 1'b0; last[0] = 32'h0; last[1] = 32'h0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("lat%0d_midrst_rdata", k + 1), rd[k], 32'h0);
      chk($sformatf("lat%0d_midrst_rvalid", k + 1), {31'h0, rv[k]}, 32'h0);
      chk($sformatf("lat%0d_midrst_err", k + 1), {31'h0, er[k]}, 32'h0);
    end
    en = 1'b1; wen = 4'hF; addr = 32'h40; wdata = 32'hBAD0BAD0;
    repeat (2) @(posedge clk);
    en = 1'b0; wen = 4'h0;
    #2;
    resetn = 1'b1;
    @(negedge clk);
    repeat (4) do_op(1'b0, 4'h0, 32'h0, 32'h0);
    do_op(1'b1, 4'h0, 32'h40, 32'h0);
    do_op(1'b1, 4'h0, 32'h8,  32'h0);

    // Random mix of reads, partial writes, idles and out-of-range accesses
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 4)       do_op(1'b1, 4'h0, $urandom & 32'hFFF, $urandom);
      else if (r < 7)  do_op(1'b1, 4'($urandom), $urandom & 32'hFFF, $urandom);
      else if (r < 9)  do_op(1'b0, 4'($urandom), $urandom, $urandom);
      else             do_op(1'b1, 4'($urandom), $urandom | 32'h1000, $urandom);
    end

    repeat (4) do_op(1'b0, 4'h0, 32'h0, 32'h0);
    chk("lat1_drain", q[0].size(), 32'd0);
    chk("lat2_drain", q[1].size(), 32'd0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word-address width; the array SHALL hold 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 1, SHALL set the read latency in cycles; the only legal values SHALL be 1 and 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 data_sram_en  input  1  access request, sampled each rising edge.
REQ-006 data_sram_wen  input  4  byte write enables; bit i SHALL cover wdata[8i+7:8i].
REQ-007 data_sram_addr  input  32  byte address.
REQ-008 data_sram_wdata  input  32  write data.
REQ-009 data_sram_rdata  output  32  read data, registered.
REQ-010 data_sram_rvalid  output  1  one-cycle pulse; marks data_sram_rdata as newly updated.
REQ-011 data_sram_err  output  1  sticky out-of-range access flag.

Function
REQ-012 Access classes, sampled at each rising edge:
- Write: en=1 and wen!=0.
- Read: en=1 and wen==0.
- Idle: en=0; inputs other than en SHALL be ignored.
REQ-013 Word index SHALL be addr[ADDR_W+1:2]; addr[1:0] SHALL be ignored; no alignment checking.
REQ-014 In range SHALL mean addr[31:ADDR_W+2]==0.
REQ-015 In-range write SHALL update only the enabled byte lanes of the addressed word, at the accepting edge; other lanes SHALL be unchanged.
REQ-016 Write SHALL NOT change rdata and SHALL NOT pulse rvalid.
REQ-017 In-range read accepted at edge N SHALL:
- drive the word onto rdata with rvalid=1 for exactly one cycle after edge N+LATENCY-1;
- with LATENCY=1, return data visible after edge N.
REQ-018 Read data SHALL reflect all writes accepted before edge N.
REQ-019 Reads SHALL be fully pipelined: one read per cycle SHALL be accepted, and results SHALL return in request order with no gaps or drops.
REQ-020 rdata SHALL hold its last value until the next read completes; rvalid SHALL be 0 in every other cycle.
REQ-021 Read-during-write, same word, same edge: not possible on this single-port interface, since a single request is one class.
REQ-022 Write at edge N followed by a read of the same word at edge N+1 SHALL return the newly written bytes (no stale forwarding hazard).
REQ-023 Out-of-range write SHALL leave the array unchanged and SHALL set err.
REQ-024 Out-of-range read SHALL complete with normal latency, return rdata=32'h0 with rvalid=1, and SHALL set err.
REQ-025 err SHALL remain 1 until reset; in-range accesses SHALL NOT clear it.
REQ-026 Array contents SHALL be X/undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-027 While resetn=0, outputs SHALL be: rdata=32'h0, rvalid=0, err=0.
REQ-028 All LATENCY pipeline stages SHALL be marked empty during reset.
REQ-029 Assertion of resetn SHALL take effect immediately, without waiting for clk.
REQ-030 A read in flight at reset assertion SHALL be discarded and SHALL NOT produce an rvalid pulse after release.
REQ-031 Writes committed before reset SHALL be preserved.
REQ-032 No access SHALL be accepted on an edge where resetn=0.
REQ-033 The first rising edge with resetn=1 SHALL accept requests normally.

Verification
REQ-034 Byte lanes, LATENCY=1: write 32'h11223344 to 0x40 with wen=4'hF, then write 32'hAABBCCDD to 0x40 with wen=4'b0101, then read 0x40 -> next cycle rdata=32'h11BB33DD, rvalid=1 for one cycle.
REQ-035 Back-to-back reads, LATENCY=2: words 0x0..0xC preloaded with 1,2,3,4; reads on 4 consecutive edges -> rvalid high for 4 consecutive cycles starting 2 cycles after the first read, rdata 1,2,3,4 in order.
REQ-036 Write-then-read: write 32'hDEADBEEF to 0x8, read 0x8 on the next edge -> rdata=32'hDEADBEEF.
REQ-037 Out of range, ADDR_W=10: write to 0x1000 -> word 0 unchanged, err=1; read 0x1000 -> rdata=0, rvalid=1; a following in-range read leaves err=1.
REQ-038 Reset mid-read, LATENCY=2: issue read, assert resetn=0 before the result returns -> rdata=0, rvalid=0, err=0 immediately; no rvalid after release; previously written data still readable.
REQ-039 Idle/ignored inputs: en=0 with wen=4'hF and random addr/wdata for 100 cycles -> array unchanged, rvalid never 1, rdata held.
